subleq_mem: RTL and testbench
=============================

Name: subleq_mem

Overview:
- Word-addressed memory and I/O stage directly downstream of the subleq CPU bus (`mem_addr`/`mem_op`/`mem_write_bytes` in, `mem_data` out).
- After reset it streams a program image in from a loader port while holding the CPU in reset, then serves CPU reads and writes.
- Writes to a dedicated I/O address are diverted into a byte-output FIFO.

Parameters:
- ADDR_BITS, 10, memory depth is 2**ADDR_BITS 64-bit words
- IO_ADDR, 64'hFFFF_FFFF_FFFF_FFFF, CPU address mapped to the output FIFO
- OUT_DEPTH, 4, output FIFO entries (power of two, >=2)

Ports:
- clk  in  1  clock, all state on posedge
- reset  in  1  asynchronous, active-high
- mem_addr  in  64  CPU word address
- mem_op  in  1  1 = write, 0 = read
- mem_write_bytes  in  64  CPU write data
- mem_data  out  64  read data to CPU
- cpu_reset  out  1  reset to CPU, high while loading
- load_valid  in  1  loader word valid
- load_data  in  64  loader word
- load_last  in  1  marks final loader word
- load_ready  out  1  loader may transfer
- out_valid  out  1  output FIFO non-empty
- out_data  out  8  head byte of output FIFO
- out_ready  in  1  consumer pops head when out_valid high
- out_overflow  out  1  sticky: I/O write dropped because FIFO full
- addr_err  out  1  sticky: out-of-range CPU access or loader overrun
- loaded_words  out  ADDR_BITS+1  number of words stored by the loader

Behaviour:
- Reset (async, active-high) forces:
  - state LOAD, load pointer 0, loaded_words 0
  - cpu_reset 1, load_ready 1
  - FIFO empty, out_valid 0, out_overflow 0, addr_err 0
  - Memory array contents are not cleared.
- States:
  - LOAD:
    - A transfer occurs when load_valid & load_ready; it writes load_data to mem[ptr] and increments ptr and loaded_words.
    - If ptr == 2**ADDR_BITS, the word is accepted but discarded and addr_err is set.
    - A transfer with load_last moves the block to RUN on the same edge.
  - RUN:
    - load_ready 0; loader inputs ignored.
    - cpu_reset drops to 0 on the edge entering RUN, giving the CPU a single rising reset edge at reset and a falling edge at load end.
    - RUN holds until the next reset.
- CPU reads:
  - mem_data is combinational from the current mem_addr. The CPU registers mem_addr on edge k and samples mem_data at edge k+1, so the effective read latency is one cycle.
  - In range (mem_addr < 2**ADDR_BITS): mem_data = mem[mem_addr[ADDR_BITS-1:0]].
  - mem_addr == IO_ADDR: mem_data = 0.
  - Any other address: mem_data = 0 and addr_err is set (RUN only, mem_op == 0).
  - In LOAD, mem_data = 0 and the CPU bus is ignored.
- CPU writes:
  - The CPU holds mem_op high for several consecutive cycles on one store. A write event is therefore defined as a posedge in RUN with mem_op == 1 and (previous-cycle mem_op == 0 or mem_addr != previous-cycle mem_addr).
  - The previous-cycle op and address registers reset to 0.
  - In-range write: the array is written every cycle mem_op == 1. This is idempotent, so no dedup is needed.
  - IO_ADDR write: on a write event only, push mem_write_bytes[7:0]. If the FIFO is full and no pop occurs on the same edge, drop the byte and set out_overflow.
  - Other addresses: no write; addr_err is set on the write event.
- FIFO:
  - out_data shows the head byte whenever out_valid is high; a pop occurs when out_valid & out_ready.
  - Push and pop on the same edge: the count is unchanged. When full, the push succeeds because the pop frees a slot.
  - Pointers wrap modulo OUT_DEPTH.
- Reset mid-load or mid-run: returns to LOAD immediately. The FIFO and all status flags are cleared, and the ptr restarts at 0.

Test Plan:
- Load a 3-word image 5, 6, 7 with load_last on the 3rd → mem[0..2] = 5, 6, 7; loaded_words = 3; cpu_reset falls on the edge accepting word 3; load_ready 0 afterwards.
- RUN, drive mem_addr = 1, mem_op = 0 → mem_data = 6 in the same cycle. Then mem_op = 1, data 42 for 3 cycles at addr 2 → mem[2] = 42.
- Hold mem_op = 1, mem_addr = IO_ADDR, data 0x141 for 3 cycles → exactly one push; out_valid = 1, out_data = 8'h41. Pop with out_ready → out_valid = 0.
- 5 distinct IO write events (mem_op toggled low between them), out_ready = 0, OUT_DEPTH = 4 → 4 bytes queued, out_overflow = 1. Repeat with out_ready = 1 on the 5th event's edge → no overflow.
- Read of addr 2**ADDR_BITS + 3 → mem_data = 0, addr_err = 1. Write to the same address → memory unchanged.
- Assert reset after 2 loader words, then reload 1 word with load_last → loaded_words = 1, mem[0] = new word, flags cleared, cpu_reset high throughout reset and load.

Source files
------------

// File: rtl/subleq_mem.sv
// subleq_mem: word memory and byte-output port behind the subleq CPU bus.
// After reset it loads a program image from the loader port, with the CPU
// held in reset. It then serves CPU reads and writes. Writes to IO_ADDR are
// pushed into a small byte FIFO instead of memory.
module subleq_mem #(
   parameter int          ADDR_BITS = 10,
   parameter logic [63:0] IO_ADDR   = 64'hFFFF_FFFF_FFFF_FFFF,
   parameter int          OUT_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [63:0]          mem_addr,
   input  logic                 mem_op,
   input  logic [63:0]          mem_write_bytes,
   output logic [63:0]          mem_data,
   output logic                 cpu_reset,
   input  logic                 load_valid,
   input  logic [63:0]          load_data,
   input  logic                 load_last,
   output logic                 load_ready,
   output logic                 out_valid,
   output logic [7:0]           out_data,
   input  logic                 out_ready,
   output logic                 out_overflow,
   output logic                 addr_err,
   output logic [ADDR_BITS:0]   loaded_words
);

   localparam int                 DEPTH     = 2 ** ADDR_BITS;
   localparam int                 OPTR_BITS = $clog2(OUT_DEPTH);
   localparam logic [ADDR_BITS:0] PTR_END   = {1'b1, {ADDR_BITS{1'b0}}};
   localparam logic [OPTR_BITS:0] FIFO_FULL = (OPTR_BITS + 1)'(OUT_DEPTH);

   typedef enum logic {LOAD, RUN} state_t;

   state_t               state, state_next;
   logic [63:0]          mem [DEPTH];
   logic [ADDR_BITS:0]   word_cnt;
   logic                 prev_op;
   logic [63:0]          prev_addr;
   logic [7:0]           fifo_mem [OUT_DEPTH];
   logic [OPTR_BITS-1:0] rd_ptr, wr_ptr;
   logic [OPTR_BITS:0]   count;

   logic is_run, in_range, is_io, load_xfer, ptr_full;
   logic write_event, push_req, push, pop, fifo_full, err_set;

   assign is_run      = (state == RUN);
   assign in_range    = (mem_addr[63:ADDR_BITS] == '0);
   assign is_io       = (mem_addr == IO_ADDR);
   assign load_xfer   = load_valid & load_ready;
   assign ptr_full    = (word_cnt == PTR_END);
   // A store holds mem_op high for several cycles; only its first cycle, or a
   // change of address, counts as a new event for the side-effecting I/O path.
   assign write_event = is_run & mem_op & (~prev_op | (mem_addr != prev_addr));
   assign fifo_full   = (count == FIFO_FULL);
   assign out_valid   = (count != '0);
   assign out_data    = fifo_mem[rd_ptr];
   assign pop         = out_valid & out_ready;
   assign push_req    = write_event & is_io;
   assign push        = push_req & (~fifo_full | pop);
   assign err_set     = (load_xfer & ptr_full)
                      | (is_run & ~in_range & ~is_io & (mem_op ? write_event : 1'b1));
   assign loaded_words = word_cnt;

   // State register: LOAD after reset, RUN once the last loader word lands.
   // NOTE: every clocked process uses non-blocking assignments so all
   // registers update together from the values sampled at the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= LOAD;
      else       state <= state_next;
   end

   // Next-state logic: RUN is entered on the edge accepting the last word.
   always_comb begin
      state_next = state;
      if (state == LOAD && load_xfer && load_last) state_next = RUN;
   end

   // State-decoded outputs: CPU held in reset and loader enabled during LOAD.
   always_comb begin
      cpu_reset  = 1'b0;
      load_ready = 1'b0;
      if (state == LOAD) begin
         cpu_reset  = 1'b1;
         load_ready = 1'b1;
      end
   end

   // Load pointer, saturating at the end of memory once overrun.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                      word_cnt <= '0;
      else if (load_xfer && !ptr_full) word_cnt <= word_cnt + 1'b1;
   end

   // Memory array writes from the loader (LOAD) or the CPU (RUN).
   // NOTE: the array has no reset; clearing it would forbid RAM inference,
   // and the program image is always reloaded before the CPU runs.
   always_ff @(posedge clk) begin
      if (load_xfer && !ptr_full)
         mem[word_cnt[ADDR_BITS-1:0]] <= load_data;
      else if (is_run && mem_op && in_range)
         mem[mem_addr[ADDR_BITS-1:0]] <= mem_write_bytes;
   end

   // Combinational read; the CPU's own address register provides the latency.
   // NOTE: the default assignment first keeps this block latch-free.
   always_comb begin
      mem_data = '0;
      if (is_run && in_range) mem_data = mem[mem_addr[ADDR_BITS-1:0]];
   end

   // Previous-cycle bus state, used to detect new write events.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_op   <= 1'b0;
         prev_addr <= '0;
      end else begin
         prev_op   <= mem_op;
         prev_addr <= mem_addr;
      end
   end

   // Output FIFO pointers and occupancy; pointers wrap naturally (power of two).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Output FIFO storage; only the pointers need clearing.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= mem_write_bytes[7:0];
   end

   // Sticky status flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_overflow <= 1'b0;
         addr_err     <= 1'b0;
      end else begin
         if (push_req && fifo_full && !pop) out_overflow <= 1'b1;
         if (err_set)                      addr_err     <= 1'b1;
      end
   end

endmodule

// File: tb/tb_subleq_mem.sv
// Testbench for subleq_mem. Directed stimulus queues the expected results;
// a monitor on the falling edge checks queued probes and every FIFO pop.
module tb_subleq_mem;

   localparam int          ADDR_BITS = 10;
   localparam logic [63:0] IO_ADDR   = 64'hFFFF_FFFF_FFFF_FFFF;

   localparam int S_MEM_DATA  = 0;
   localparam int S_CPU_RESET = 1;
   localparam int S_LOAD_RDY  = 2;
   localparam int S_OUT_VALID = 3;
   localparam int S_OUT_DATA  = 4;
   localparam int S_OVERFLOW  = 5;
   localparam int S_ADDR_ERR  = 6;
   localparam int S_LOADED    = 7;

   typedef struct {
      string       name;
      int          sel;
      logic [63:0] exp;
   } probe_t;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [63:0]          mem_addr;
   logic                 mem_op;
   logic [63:0]          mem_write_bytes;
   logic [63:0]          mem_data;
   logic                 cpu_reset;
   logic                 load_valid;
   logic [63:0]          load_data;
   logic                 load_last;
   logic                 load_ready;
   logic                 out_valid;
   logic [7:0]           out_data;
   logic                 out_ready;
   logic                 out_overflow;
   logic                 addr_err;
   logic [ADDR_BITS:0]   loaded_words;

   probe_t     probe_q[$];
   logic [7:0] byte_q[$];
   int         n_vec  = 0;
   int         n_miss = 0;

   subleq_mem #(.ADDR_BITS(ADDR_BITS), .IO_ADDR(IO_ADDR), .OUT_DEPTH(4)) dut (
      .clk             (clk),
      .reset           (reset),
      .mem_addr        (mem_addr),
      .mem_op          (mem_op),
      .mem_write_bytes (mem_write_bytes),
      .mem_data        (mem_data),
      .cpu_reset       (cpu_reset),
      .load_valid      (load_valid),
      .load_data       (load_data),
      .load_last       (load_last),
      .load_ready      (load_ready),
      .out_valid       (out_valid),
      .out_data        (out_data),
      .out_ready       (out_ready),
      .out_overflow    (out_overflow),
      .addr_err        (addr_err),
      .loaded_words    (loaded_words)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] sample(input int sel);
      case (sel)
         S_MEM_DATA:  return mem_data;
         S_CPU_RESET: return 64'(cpu_reset);
         S_LOAD_RDY:  return 64'(load_ready);
         S_OUT_VALID: return 64'(out_valid);
         S_OUT_DATA:  return 64'(out_data);
         S_OVERFLOW:  return 64'(out_overflow);
         S_ADDR_ERR:  return 64'(addr_err);
         S_LOADED:    return 64'(loaded_words);
         default:     return 'x;
      endcase
   endfunction

   // Monitor: drain queued probes and check each byte the consumer pops.
   always @(negedge clk) begin
      while (probe_q.size() > 0) begin
         probe_t p;
         logic [63:0] act;
         p   = probe_q.pop_front();
         act = sample(p.sel);
         n_vec++;
         if (act !== p.exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", p.name, act, p.exp);
         end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         n_vec++;
         if (byte_q.size() == 0) begin
            n_miss++;
            $display("FAIL unexpected_pop: got %h, expected no byte", out_data);
         end else begin
            logic [7:0] e;
            e = byte_q.pop_front();
            if (out_data !== e) begin
               n_miss++;
               $display("FAIL fifo_byte: got %h, expected %h", out_data, e);
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic probe(input string name, input int sel, input logic [63:0] exp);
      probe_t p;
      p.name = name;
      p.sel  = sel;
      p.exp  = exp;
      probe_q.push_back(p);
   endtask

   // One distinct I/O write event followed by an idle cycle.
   task automatic io_event(input logic [7:0] b, input bit expect_push);
      mem_addr        = IO_ADDR;
      mem_op          = 1'b1;
      mem_write_bytes = {56'h0, b};
      if (expect_push) byte_q.push_back(b);
      tick();
      mem_op = 1'b0;
      tick();
   endtask

   task automatic drain4();
      out_ready = 1'b1;
      repeat (4) tick();
      out_ready = 1'b0;
      probe("fifo_empty_after_drain", S_OUT_VALID, 64'd0);
      tick();
   endtask

   initial begin
      reset = 1'b1; mem_addr = '0; mem_op = 1'b0; mem_write_bytes = '0;
      load_valid = 1'b0; load_data = '0; load_last = 1'b0; out_ready = 1'b0;
      repeat (2) tick();
      probe("rst_cpu_reset",  S_CPU_RESET, 64'd1);
      probe("rst_load_ready", S_LOAD_RDY,  64'd1);
      probe("rst_out_valid",  S_OUT_VALID, 64'd0);
      probe("rst_overflow",   S_OVERFLOW,  64'd0);
      probe("rst_addr_err",   S_ADDR_ERR,  64'd0);
      probe("rst_loaded",     S_LOADED,    64'd0);
      probe("load_mem_data",  S_MEM_DATA,  64'd0);
      tick();
      reset = 1'b0;

      // Load image 5, 6, 7.
      load_valid = 1'b1; load_data = 64'd5; tick();
      load_data = 64'd6; tick();
      load_data = 64'd7; load_last = 1'b1;
      probe("cpu_reset_before_last", S_CPU_RESET, 64'd1);
      tick();
      load_valid = 1'b0; load_last = 1'b0;
      probe("cpu_reset_run",  S_CPU_RESET, 64'd0);
      probe("load_ready_run", S_LOAD_RDY,  64'd0);
      probe("loaded_3",       S_LOADED,    64'd3);
      load_valid = 1'b1; load_data = 64'd9; tick();
      load_valid = 1'b0;
      probe("loader_ignored_in_run", S_LOADED, 64'd3);

      // Reads of the image.
      mem_addr = 64'd0; probe("rd_mem0", S_MEM_DATA, 64'd5); tick();
      mem_addr = 64'd1; probe("rd_mem1", S_MEM_DATA, 64'd6); tick();
      mem_addr = 64'd2; probe("rd_mem2", S_MEM_DATA, 64'd7); tick();

      // Held store of 42 to addr 2, and 11 to addr 3.
      mem_op = 1'b1; mem_write_bytes = 64'd42; repeat (3) tick();
      mem_op = 1'b0; probe("rd_mem2_after_wr", S_MEM_DATA, 64'd42); tick();
      mem_addr = 64'd3; mem_op = 1'b1; mem_write_bytes = 64'd11; tick();
      mem_op = 1'b0; probe("rd_mem3_after_wr", S_MEM_DATA, 64'd11); tick();

      // Held I/O store: exactly one byte pushed.
      mem_addr = IO_ADDR; mem_op = 1'b1; mem_write_bytes = 64'h141;
      byte_q.push_back(8'h41);
      repeat (3) tick();
      mem_op = 1'b0;
      probe("io_read_zero",    S_MEM_DATA,  64'd0);
      probe("io_out_valid",    S_OUT_VALID, 64'd1);
      probe("io_out_data",     S_OUT_DATA,  64'h41);
      tick();
      probe("io_no_addr_err",  S_ADDR_ERR,  64'd0);
      out_ready = 1'b1; tick();
      out_ready = 1'b0;
      probe("io_single_push",  S_OUT_VALID, 64'd0);
      tick();

      // Full FIFO with a pop on the 5th event's edge: no overflow.
      for (int i = 0; i < 4; i++) io_event(8'h20 + 8'(i), 1'b1);
      mem_addr = IO_ADDR; mem_op = 1'b1; mem_write_bytes = 64'h24; out_ready = 1'b1;
      byte_q.push_back(8'h24);
      tick();
      mem_op = 1'b0; out_ready = 1'b0;
      probe("full_pop_push_no_ovf", S_OVERFLOW,  64'd0);
      probe("full_pop_push_valid",  S_OUT_VALID, 64'd1);
      tick();
      drain4();

      // Five events with no consumer: four queued, fifth dropped.
      for (int i = 0; i < 5; i++) io_event(8'h10 + 8'(i), i < 4);
      probe("overflow_set",  S_OVERFLOW, 64'd1);
      probe("overflow_head", S_OUT_DATA, 64'h10);
      drain4();
      probe("no_addr_err_yet", S_ADDR_ERR, 64'd0);

      // Out-of-range read and write.
      mem_addr = 64'd1027; mem_op = 1'b0;
      probe("oob_read_zero", S_MEM_DATA, 64'd0);
      tick();
      probe("oob_addr_err", S_ADDR_ERR, 64'd1);
      mem_op = 1'b1; mem_write_bytes = 64'd99; repeat (2) tick();
      mem_op = 1'b0; mem_addr = 64'd3;
      probe("oob_write_no_alias", S_MEM_DATA, 64'd11);
      tick();

      // Reset mid-run, partial load, reset mid-load, then reload one word.
      mem_addr = 64'd0;
      reset = 1'b1;
      probe("rrst_cpu_reset", S_CPU_RESET, 64'd1);
      probe("rrst_overflow",  S_OVERFLOW,  64'd0);
      probe("rrst_addr_err",  S_ADDR_ERR,  64'd0);
      probe("rrst_loaded",    S_LOADED,    64'd0);
      probe("rrst_load_rdy",  S_LOAD_RDY,  64'd1);
      tick();
      reset = 1'b0;
      load_valid = 1'b1; load_data = 64'hAA; tick();
      load_data = 64'hBB; tick();
      load_valid = 1'b0;
      probe("partial_loaded",    S_LOADED,    64'd2);
      probe("partial_cpu_reset", S_CPU_RESET, 64'd1);
      probe("partial_mem_zero",  S_MEM_DATA,  64'd0);
      tick();
      reset = 1'b1;
      probe("mid_load_rst_loaded", S_LOADED,    64'd0);
      probe("mid_load_rst_cpu",    S_CPU_RESET, 64'd1);
      tick();
      reset = 1'b0;
      load_valid = 1'b1; load_data = 64'hCC; load_last = 1'b1;
      probe("reload_cpu_reset", S_CPU_RESET, 64'd1);
      tick();
      load_valid = 1'b0; load_last = 1'b0;
      probe("reload_loaded",    S_LOADED,    64'd1);
      probe("reload_cpu_run",   S_CPU_RESET, 64'd0);
      probe("reload_mem0",      S_MEM_DATA,  64'hCC);
      tick();
      mem_addr = 64'd1;
      probe("reload_mem1_kept", S_MEM_DATA, 64'hBB);
      tick();
      repeat (2) tick();

      n_vec++;
      if (byte_q.size() != 0) begin
         n_miss++;
         $display("FAIL bytes_outstanding: got %0d left, expected 0", byte_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
